// File: rtl/lrhls_top_prod_accum.sv
// ============================================================================
// lrhls_top_prod_accum : saturating signed per-frame accumulator of multiplier
//                        products, one sum per frame on a valid/ready output.
// Revision 1.0
// ============================================================================
`default_nettype none

module lrhls_top_prod_accum #(
  parameter int PROD_WIDTH = 36,
  parameter int ACC_WIDTH  = 48,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [PROD_WIDTH-1:0] prod_in,
  input  logic                  prod_valid,
  input  logic                  prod_last,
  output logic                  prod_ready,
  output logic [ACC_WIDTH-1:0]  sum_out,
  output logic [CNT_WIDTH-1:0]  sum_count,
  output logic                  sum_ovf,
  output logic                  sum_valid,
  input  logic                  sum_ready
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_WIDTH-1:0]   sum_cnt_q, sum_cnt_d;
  logic                   sum_ovf_q, sum_ovf_d;
  logic                   sum_valid_q, sum_valid_d;

  logic                   beat;
  logic [ACC_WIDTH:0]     prod_ext;
  logic [ACC_WIDTH:0]     base_ext;
  logic [ACC_WIDTH:0]     raw_sum;
  logic                   add_ovf;
  logic [ACC_WIDTH-1:0]   sat_sum;
  logic                   cnt_ovf;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  logic                   ovf_nxt;

  assign prod_ready = ~sum_valid_q | sum_ready;
  assign beat       = prod_valid & prod_ready;

  // One guard bit above ACC_WIDTH exposes signed overflow as a sign mismatch.
  assign prod_ext = {{(ACC_WIDTH + 1 - PROD_WIDTH){prod_in[PROD_WIDTH-1]}}, prod_in};
  assign base_ext = (state_q == S_ACCUM) ? {acc_q[ACC_WIDTH-1], acc_q} : '0;
  assign raw_sum  = base_ext + prod_ext;
  assign add_ovf  = raw_sum[ACC_WIDTH] ^ raw_sum[ACC_WIDTH-1];
  assign sat_sum  = add_ovf ? (raw_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                            : raw_sum[ACC_WIDTH-1:0];

  assign cnt_ovf = (state_q == S_ACCUM) && (cnt_q == CNT_MAX);
  assign cnt_nxt = (state_q == S_EMPTY) ? CNT_ONE
                 : (cnt_ovf ? CNT_MAX : cnt_q + CNT_ONE);
  assign ovf_nxt = ((state_q == S_ACCUM) & ovf_q) | add_ovf | cnt_ovf;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    sum_d       = sum_q;
    sum_cnt_d   = sum_cnt_q;
    sum_ovf_d   = sum_ovf_q;
    sum_valid_d = sum_valid_q & ~sum_ready;

    if (beat) begin
      if (prod_last) begin
        state_d     = S_EMPTY;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        sum_d       = sat_sum;
        sum_cnt_d   = cnt_nxt;
        sum_ovf_d   = ovf_nxt;
        sum_valid_d = 1'b1;
      end else begin
        state_d = S_ACCUM;
        acc_d   = sat_sum;
        cnt_d   = cnt_nxt;
        ovf_d   = ovf_nxt;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_EMPTY;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_q       <= '0;
      sum_cnt_q   <= '0;
      sum_ovf_q   <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      sum_q       <= sum_d;
      sum_cnt_q   <= sum_cnt_d;
      sum_ovf_q   <= sum_ovf_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum_out   = sum_q;
  assign sum_count = sum_cnt_q;
  assign sum_ovf   = sum_ovf_q;
  assign sum_valid = sum_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_lrhls_top_prod_accum.sv
// ============================================================================
// tb_lrhls_top_prod_accum : directed, table-driven bench for the accumulator.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_lrhls_top_prod_accum;

  logic                ap_clk;
  logic                ap_rst_n;
  logic signed [35:0]  prod_in;
  logic                prod_valid;
  logic                prod_last;
  logic                prod_ready;
  logic signed [47:0]  sum_out;
  logic [3:0]          sum_count;
  logic                sum_ovf;
  logic                sum_valid;
  logic                sum_ready;

  int n_tests = 0;
  int n_fail  = 0;

  lrhls_top_prod_accum #(
    .PROD_WIDTH (36),
    .ACC_WIDTH  (48),
    .CNT_WIDTH  (4)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (prod_ready),
    .sum_out    (sum_out),
    .sum_count  (sum_count),
    .sum_ovf    (sum_ovf),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic               v;
    logic signed [35:0] p;
    logic               l;
    logic               sr;
    logic               e_pr;
    logic               e_sv;
    logic signed [47:0] e_sum;
    logic [3:0]         e_cnt;
    logic               e_ovf;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  localparam logic signed [63:0] ACC_MAX = 64'sd140737488355327;
  localparam logic signed [63:0] ACC_MIN = -64'sd140737488355328;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives an n-beat frame of a constant value with sum_ready high and checks
  // the sum that appears one cycle after the last beat.
  task automatic send_frame(input string name, input int n,
                            input logic signed [35:0] val,
                            input logic signed [63:0] e_sum,
                            input logic [3:0] e_cnt, input logic e_ovf);
    int stalls = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge ap_clk);
      prod_valid = 1'b1;
      prod_in    = val;
      prod_last  = (i == n - 1);
      sum_ready  = 1'b1;
      #1;
      if (!prod_ready) stalls++;
    end
    @(negedge ap_clk);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    #1;
    check({name, " ready_stalls"}, stalls, 0);
    check({name, " sum_valid"}, sum_valid, 1);
    check({name, " sum_out"}, sum_out, e_sum);
    check({name, " sum_count"}, sum_count, e_cnt);
    check({name, " sum_ovf"}, sum_ovf, e_ovf);
    @(negedge ap_clk);
    #1;
    check({name, " valid_clears"}, sum_valid, 0);
  endtask

  initial begin
    // Per-cycle rows: inputs held for that cycle; expectations are the
    // outputs seen before the cycle's rising edge.
    tbl[0]  = '{1'b1, 36'sd100, 1'b0, 1'b1, 1'b1, 1'b0, 48'sd0,  4'd0, 1'b0};
    tbl[1]  = '{1'b1, -36'sd30, 1'b0, 1'b1, 1'b1, 1'b0, 48'sd0,  4'd0, 1'b0};
    tbl[2]  = '{1'b1, 36'sd7,   1'b1, 1'b1, 1'b1, 1'b0, 48'sd0,  4'd0, 1'b0};
    tbl[3]  = '{1'b1, -36'sd5,  1'b1, 1'b1, 1'b1, 1'b1, 48'sd77, 4'd3, 1'b0};
    tbl[4]  = '{1'b1, 36'sd12,  1'b1, 1'b1, 1'b1, 1'b1, -48'sd5, 4'd1, 1'b0};
    tbl[5]  = '{1'b1, 36'sd0,   1'b1, 1'b1, 1'b1, 1'b1, 48'sd12, 4'd1, 1'b0};
    tbl[6]  = '{1'b0, 36'sd55,  1'b1, 1'b1, 1'b1, 1'b1, 48'sd0,  4'd1, 1'b0};
    tbl[7]  = '{1'b0, 36'sd0,   1'b0, 1'b1, 1'b1, 1'b0, 48'sd0,  4'd0, 1'b0};
    tbl[8]  = '{1'b1, 36'sd1,   1'b0, 1'b0, 1'b1, 1'b0, 48'sd0,  4'd0, 1'b0};
    tbl[9]  = '{1'b1, 36'sd2,   1'b1, 1'b0, 1'b1, 1'b0, 48'sd0,  4'd0, 1'b0};
    tbl[10] = '{1'b1, 36'sd3,   1'b0, 1'b0, 1'b0, 1'b1, 48'sd3,  4'd2, 1'b0};
    tbl[11] = '{1'b1, 36'sd3,   1'b0, 1'b0, 1'b0, 1'b1, 48'sd3,  4'd2, 1'b0};
    tbl[12] = '{1'b1, 36'sd3,   1'b0, 1'b0, 1'b0, 1'b1, 48'sd3,  4'd2, 1'b0};
    tbl[13] = '{1'b1, 36'sd3,   1'b0, 1'b0, 1'b0, 1'b1, 48'sd3,  4'd2, 1'b0};
    tbl[14] = '{1'b1, 36'sd3,   1'b0, 1'b1, 1'b1, 1'b1, 48'sd3,  4'd2, 1'b0};
    tbl[15] = '{1'b1, 36'sd4,   1'b1, 1'b1, 1'b1, 1'b0, 48'sd0,  4'd0, 1'b0};
    tbl[16] = '{1'b0, 36'sd0,   1'b0, 1'b1, 1'b1, 1'b1, 48'sd7,  4'd2, 1'b0};
    tbl[17] = '{1'b0, 36'sd0,   1'b0, 1'b1, 1'b1, 1'b0, 48'sd0,  4'd0, 1'b0};

    ap_rst_n   = 1'b0;
    prod_in    = '0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    sum_ready  = 1'b1;
    repeat (2) @(negedge ap_clk);
    #1;
    check("reset sum_valid", sum_valid, 0);
    check("reset sum_out", sum_out, 0);
    check("reset sum_count", sum_count, 0);
    check("reset sum_ovf", sum_ovf, 0);
    check("reset prod_ready", prod_ready, 1);
    ap_rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge ap_clk);
      prod_valid = tbl[i].v;
      prod_in    = tbl[i].p;
      prod_last  = tbl[i].l;
      sum_ready  = tbl[i].sr;
      #1;
      check($sformatf("row%0d prod_ready", i), prod_ready, tbl[i].e_pr);
      check($sformatf("row%0d sum_valid", i), sum_valid, tbl[i].e_sv);
      if (tbl[i].e_sv) begin
        check($sformatf("row%0d sum_out", i), sum_out, tbl[i].e_sum);
        check($sformatf("row%0d sum_count", i), sum_count, tbl[i].e_cnt);
        check($sformatf("row%0d sum_ovf", i), sum_ovf, tbl[i].e_ovf);
      end
    end

    // Beat-counter boundary: 15 beats fill the counter, a 16th overflows it.
    send_frame("cnt15", 15, 36'sd1, 64'sd15, 4'd15, 1'b0);
    send_frame("cnt16", 16, 36'sd1, 64'sd16, 4'd15, 1'b1);

    // 4096 beats of ~2^35 are needed to exceed the 48-bit range.
    send_frame("sat_pos", 5000, 36'sh7_FFFF_FFFF, ACC_MAX, 4'd15, 1'b1);
    send_frame("after_pos", 1, -36'sd1, -64'sd1, 4'd1, 1'b0);
    send_frame("sat_neg", 5000, 36'sh8_0000_0000, ACC_MIN, 4'd15, 1'b1);
    send_frame("after_neg", 1, 36'sd21, 64'sd21, 4'd1, 1'b0);

    // Mid-frame reset discards the partial frame 50, 60.
    @(negedge ap_clk);
    prod_valid = 1'b1; prod_in = 36'sd50; prod_last = 1'b0; sum_ready = 1'b1;
    @(negedge ap_clk);
    prod_in = 36'sd60;
    @(negedge ap_clk);
    prod_valid = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("midrst sum_valid", sum_valid, 0);
    check("midrst sum_out", sum_out, 0);
    check("midrst sum_count", sum_count, 0);
    check("midrst sum_ovf", sum_ovf, 0);
    check("midrst prod_ready", prod_ready, 1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    send_frame("post_rst", 1, 36'sd9, 64'sd9, 4'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
